// File: rtl/psum_router.sv
// psum_router: routes per-lane signed partial sums from several CIM macros into
// OUT_CH channel accumulators and presents the result once per tile.
// A tile closes after NUM_BEATS accepted beats, or early when flush is seen.
// Build option: define PSUM_ROUTER_SAT_EN to make accumulators saturate and
// raise sticky per-channel overflow flags; otherwise they wrap and overflow is 0.
module psum_router #(
    parameter int unsigned NUM_MACRO      = 2,
    parameter int unsigned MAX_NUM_FILTER = 2,
    parameter int unsigned OUT_CH         = 8,
    parameter int unsigned PSUM_W         = 16,
    parameter int unsigned ACC_W          = 20,
    parameter int unsigned NUM_BEATS      = 4
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [NUM_MACRO*MAX_NUM_FILTER*$clog2(OUT_CH)-1:0]  WHICH_FILTER,
    input  logic [NUM_MACRO*MAX_NUM_FILTER-1:0]                 FILTER_EN,
    input  logic [NUM_MACRO*MAX_NUM_FILTER*PSUM_W-1:0]          PSUM,
    input  logic                                                flush,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [OUT_CH*ACC_W-1:0]                             out_acc,
    output logic [OUT_CH-1:0]                                   overflow
);

    localparam int unsigned L     = NUM_MACRO * MAX_NUM_FILTER;
    localparam int unsigned CW    = $clog2(OUT_CH);
    // Beat sum is wide enough to hold all L lanes colliding on one channel.
    localparam int unsigned SUM_W = PSUM_W + $clog2(L) + 1;
    // One bit beyond the wider operand so acc + beat_sum can never wrap.
    localparam int unsigned EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam int unsigned CNT_W = $clog2(NUM_BEATS + 1);

    typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic signed [ACC_W-1:0]   acc_q [OUT_CH];
    logic signed [ACC_W-1:0]   acc_d [OUT_CH];
    logic signed [ACC_W-1:0]   upd [OUT_CH];
    logic signed [SUM_W-1:0]   beat_sum [OUT_CH];
    logic signed [EXT_W-1:0]   wide [OUT_CH];
    logic                      accept;
`ifdef PSUM_ROUTER_SAT_EN
    logic [OUT_CH-1:0]         clip;
    logic [OUT_CH-1:0]         ovf_q, ovf_d;
`endif

    assign in_ready  = (state_q != StDrain);
    assign out_valid = (state_q == StDrain);
    assign accept    = in_valid && in_ready;

    // Per-channel sum of all enabled lanes targeting it; out-of-range targets match nothing.
    always_comb begin
        for (int c = 0; c < OUT_CH; c++) begin
            beat_sum[c] = '0;
            for (int l = 0; l < L; l++) begin
                if (FILTER_EN[l] && (WHICH_FILTER[l*CW +: CW] == CW'(c))) begin
                    beat_sum[c] = beat_sum[c]
                                + {{(SUM_W-PSUM_W){PSUM[l*PSUM_W+PSUM_W-1]}},
                                   PSUM[l*PSUM_W +: PSUM_W]};
                end
            end
        end
    end

    // Candidate accumulator values for an accepted beat (saturating or wrapping).
    always_comb begin
        for (int c = 0; c < OUT_CH; c++) begin
            wide[c] = {{(EXT_W-ACC_W){acc_q[c][ACC_W-1]}}, acc_q[c]}
                    + {{(EXT_W-SUM_W){beat_sum[c][SUM_W-1]}}, beat_sum[c]};
`ifdef PSUM_ROUTER_SAT_EN
            // Out of range when the bits above the result sign bit disagree with it.
            clip[c] = (wide[c][EXT_W-1:ACC_W-1] != {(EXT_W-ACC_W+1){wide[c][EXT_W-1]}});
            if (!clip[c]) begin
                upd[c] = wide[c][ACC_W-1:0];
            end else if (wide[c][EXT_W-1]) begin
                upd[c] = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                upd[c] = {1'b0, {(ACC_W-1){1'b1}}};
            end
`else
            upd[c] = ACC_W'(wide[c]);
`endif
        end
    end

    // Tile FSM: beat counting, tile close on last beat or flush, clear on result handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
`ifdef PSUM_ROUTER_SAT_EN
        ovf_d   = ovf_q;
`endif
        cnt_inc = cnt_q + CNT_W'(1);
        case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    acc_d = upd;
`ifdef PSUM_ROUTER_SAT_EN
                    ovf_d = ovf_q | clip;
`endif
                    if ((cnt_inc == CNT_W'(NUM_BEATS)) || flush) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StAccum;
                    end
                end else if (flush && (state_q == StAccum)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    for (int c = 0; c < OUT_CH; c++) begin
                        acc_d[c] = '0;
                    end
`ifdef PSUM_ROUTER_SAT_EN
                    ovf_d   = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, beat counter, accumulators and flags; async reset drops any partial tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int c = 0; c < OUT_CH; c++) begin
                acc_q[c] <= '0;
            end
`ifdef PSUM_ROUTER_SAT_EN
            ovf_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
`ifdef PSUM_ROUTER_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Result bus is zero except while a result is presented.
    always_comb begin
        for (int c = 0; c < OUT_CH; c++) begin
            out_acc[c*ACC_W +: ACC_W] = out_valid ? acc_q[c] : '0;
        end
    end

`ifdef PSUM_ROUTER_SAT_EN
    assign overflow = ovf_q;
`else
    assign overflow = '0;
`endif

endmodule

// File: tb/tb_psum_router.sv
// Directed bench for psum_router: default instance, an OUT_CH=6 instance and an
// ACC_W=18 instance share one stimulus stream and are checked against hand values.
module tb_psum_router;

`ifdef PSUM_ROUTER_SAT_EN
    localparam int       SAT_CH0 = 131071;
    localparam bit [7:0] SAT_OVF = 8'h01;
`else
    localparam int       SAT_CH0 = -16;
    localparam bit [7:0] SAT_OVF = 8'h00;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, flush, out_ready;
    logic [11:0]  wf;
    logic [3:0]   en;
    logic [63:0]  ps;

    logic         d_in_ready, d_out_valid;
    logic [159:0] d_acc;
    logic [7:0]   d_ovf;
    logic         m_in_ready, m_out_valid;
    logic [119:0] m_acc;
    logic [5:0]   m_ovf;
    logic         s_in_ready, s_out_valid;
    logic [143:0] s_acc;
    logic [7:0]   s_ovf;

    int errors = 0;
    int checks = 0;

    psum_router u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .WHICH_FILTER(wf), .FILTER_EN(en), .PSUM(ps), .flush(flush),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_acc(d_acc), .overflow(d_ovf)
    );

    psum_router #(.OUT_CH(6)) u_ch6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .WHICH_FILTER(wf), .FILTER_EN(en), .PSUM(ps), .flush(flush),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_acc(m_acc), .overflow(m_ovf)
    );

    psum_router #(.ACC_W(18)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .WHICH_FILTER(wf), .FILTER_EN(en), .PSUM(ps), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_acc), .overflow(s_ovf)
    );

    function automatic logic signed [19:0] d_ch(input int c);
        return d_acc[c*20 +: 20];
    endfunction

    function automatic logic signed [19:0] m_ch(input int c);
        return m_acc[c*20 +: 20];
    endfunction

    task automatic set_lanes(input int w0, input int w1, input int w2, input int w3,
                             input int p0, input int p1, input int p2, input int p3,
                             input logic [3:0] e);
        wf = {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
        ps = {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
        en = e;
    endtask

    // One accepted beat on the next rising edge; returns 1 time unit after it.
    task automatic beat(input logic fl);
        in_valid = 1'b1;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (d_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", d_out_valid);
        end
        checks++;
        if (d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", d_in_ready);
        end
        checks++;
        if (d_acc !== '0) begin
            errors++;
            $display("FAIL reset_out_acc: got %h expected 0", d_acc);
        end
        checks++;
        if (d_ovf !== 8'h00) begin
            errors++;
            $display("FAIL reset_overflow: got %h expected 00", d_ovf);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got ready=%b valid=%b expected 1/0",
                     d_in_ready, d_out_valid);
        end
    endtask

    task automatic test_basic();
        int exp[8] = '{4, 8, 12, 16, 0, 0, 0, 0};
        set_lanes(0, 1, 2, 3, 1, 2, 3, 4, 4'hf);
        repeat (3) beat(1'b0);
        checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_before_last: got valid=%b ready=%b expected 0/1",
                     d_out_valid, d_in_ready);
        end
        beat(1'b0);
        checks++;
        if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: got valid=%b ready=%b expected 1/0",
                     d_out_valid, d_in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (d_ch(c) !== 20'(exp[c])) begin
                errors++;
                $display("FAIL basic_ch%0d: got %0d expected %0d", c, d_ch(c), exp[c]);
            end
        end
        handshake();
        checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1 || d_acc !== '0) begin
            errors++;
            $display("FAIL basic_release: got valid=%b ready=%b acc=%h expected 0/1/0",
                     d_out_valid, d_in_ready, d_acc);
        end
    endtask

    task automatic test_collision_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_idle: got valid=%b ready=%b expected 0/1",
                     d_out_valid, d_in_ready);
        end
        set_lanes(5, 5, 5, 5, 10, -3, 7, 1, 4'hf);
        beat(1'b0);
        checks++;
        if (d_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL collision_accum: got valid=%b expected 0", d_out_valid);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (d_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_drain: got valid=%b expected 1", d_out_valid);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (d_ch(c) !== ((c == 5) ? 20'sd15 : 20'sd0)) begin
                errors++;
                $display("FAIL collision_ch%0d: got %0d expected %0d", c, d_ch(c),
                         (c == 5) ? 15 : 0);
            end
        end
        handshake();
    endtask

    task automatic test_flush_with_beat();
        int exp[8] = '{2, 4, 6, 8, 0, 0, 0, 0};
        set_lanes(0, 1, 2, 3, 1, 2, 3, 4, 4'hf);
        beat(1'b0);
        beat(1'b1);
        checks++;
        if (d_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_beat_drain: got valid=%b expected 1", d_out_valid);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (d_ch(c) !== 20'(exp[c])) begin
                errors++;
                $display("FAIL flush_beat_ch%0d: got %0d expected %0d", c, d_ch(c), exp[c]);
            end
        end
        handshake();
    endtask

    task automatic test_mask_range();
        int exp[6] = '{5, 6, 0, 0, 0, 0};
        // lane2 targets ch7 (out of range for 6 channels), lane3 is disabled
        set_lanes(0, 1, 7, 2, 5, 6, 50, 100, 4'b0111);
        beat(1'b1);
        checks++;
        if (m_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mask_drain: got valid=%b expected 1", m_out_valid);
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (m_ch(c) !== 20'(exp[c])) begin
                errors++;
                $display("FAIL mask_ch6_ch%0d: got %0d expected %0d", c, m_ch(c), exp[c]);
            end
        end
        checks++;
        if (d_ch(7) !== 20'sd50 || d_ch(2) !== 20'sd0) begin
            errors++;
            $display("FAIL mask_def: got ch7=%0d ch2=%0d expected 50/0", d_ch(7), d_ch(2));
        end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [159:0] exp_v;
        exp_v = {20'd0, 20'd0, 20'd0, 20'd0, 20'd16, 20'd12, 20'd8, 20'd4};
        set_lanes(0, 1, 2, 3, 1, 2, 3, 4, 4'hf);
        repeat (4) beat(1'b0);
        set_lanes(1, 1, 1, 1, 9, 9, 9, 9, 4'hf);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            flush    = (i == 1);
            @(posedge clk);
            #1;
            checks++;
            if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0 || d_acc !== exp_v) begin
                errors++;
                $display("FAIL backpressure_c%0d: got valid=%b ready=%b acc=%h expected 1/0/%h",
                         i, d_out_valid, d_in_ready, d_acc, exp_v);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        handshake();
        checks++;
        if (d_in_ready !== 1'b1 || d_acc !== '0) begin
            errors++;
            $display("FAIL backpressure_release: got ready=%b acc=%h expected 1/0",
                     d_in_ready, d_acc);
        end
        set_lanes(0, 1, 2, 3, 1, 2, 3, 4, 4'hf);
        beat(1'b1);
        exp_v = {20'd0, 20'd0, 20'd0, 20'd0, 20'd4, 20'd3, 20'd2, 20'd1};
        checks++;
        if (d_acc !== exp_v) begin
            errors++;
            $display("FAIL backpressure_cleared: got %h expected %h", d_acc, exp_v);
        end
        handshake();
    endtask

    task automatic test_saturation();
        logic signed [17:0] s0;
        set_lanes(0, 0, 0, 0, 32767, 32767, 32767, 32767, 4'hf);
        repeat (4) beat(1'b0);
        s0 = s_acc[17:0];
        checks++;
        if (s_out_valid !== 1'b1 || s0 !== 18'(SAT_CH0)) begin
            errors++;
            $display("FAIL sat_ch0: got valid=%b val=%0d expected 1/%0d", s_out_valid, s0, SAT_CH0);
        end
        checks++;
        if (s_ovf !== SAT_OVF) begin
            errors++;
            $display("FAIL sat_overflow: got %h expected %h", s_ovf, SAT_OVF);
        end
        checks++;
        if (s_acc[143:18] !== '0) begin
            errors++;
            $display("FAIL sat_other_ch: got %h expected 0", s_acc[143:18]);
        end
        checks++;
        if (d_ch(0) !== 20'sd524272 || d_ovf !== 8'h00) begin
            errors++;
            $display("FAIL sat_wide_ch0: got %0d ovf=%h expected 524272/00", d_ch(0), d_ovf);
        end
        handshake();
        checks++;
        if (s_ovf !== 8'h00 || s_acc !== '0) begin
            errors++;
            $display("FAIL sat_clear: got ovf=%h acc=%h expected 0/0", s_ovf, s_acc);
        end
    endtask

    task automatic test_reset_mid();
        logic [159:0] exp_v;
        exp_v = {20'd0, 20'd0, 20'd0, 20'd0, 20'd16, 20'd12, 20'd8, 20'd4};
        set_lanes(0, 1, 2, 3, 1, 2, 3, 4, 4'hf);
        repeat (2) beat(1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1 || d_acc !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got valid=%b ready=%b acc=%h expected 0/1/0",
                     d_out_valid, d_in_ready, d_acc);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) beat(1'b0);
        checks++;
        if (d_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_count: got valid=%b expected 0", d_out_valid);
        end
        beat(1'b0);
        checks++;
        if (d_out_valid !== 1'b1 || d_acc !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_result: got valid=%b acc=%h expected 1/%h",
                     d_out_valid, d_acc, exp_v);
        end
        handshake();
    endtask

    initial begin
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        wf        = '0;
        en        = '0;
        ps        = '0;
        test_reset();
        test_basic();
        test_collision_flush();
        test_flush_with_beat();
        test_mask_range();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/psum_router.md
PSUM_ROUTER -- requirements
Module: psum_router

Interface
REQ-001 SHALL have parameter NUM_MACRO, default 2: number of CIM macros feeding partial sums.
REQ-002 SHALL have parameter MAX_NUM_FILTER, default 2: filter lanes per macro; L = NUM_MACRO*MAX_NUM_FILTER lanes total.
REQ-003 SHALL have parameter OUT_CH, default 8: number of output-channel accumulators; CW = $clog2(OUT_CH).
REQ-004 SHALL have parameter PSUM_W, default 16: signed partial-sum width per lane.
REQ-005 SHALL have parameter ACC_W, default 20: signed accumulator width per channel.
REQ-006 SHALL have parameter NUM_BEATS, default 4: beats accumulated per output tile.
REQ-007 SHALL have port clk  in  1  clock, rising edge.
REQ-008 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port in_valid  in  1  input beat valid.
REQ-010 SHALL have port in_ready  out  1  router can accept a beat.
REQ-011 SHALL have port WHICH_FILTER  in  L*CW  lane l's target channel at bits [l*CW +: CW], with l = macro*MAX_NUM_FILTER + filter.
REQ-012 SHALL have port FILTER_EN  in  L  per-lane enable.
REQ-013 SHALL have port PSUM  in  L*PSUM_W  lane l's signed partial sum at [l*PSUM_W +: PSUM_W].
REQ-014 SHALL have port flush  in  1  early tile close.
REQ-015 SHALL have port out_valid  out  1  tile result valid.
REQ-016 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-017 SHALL have port out_acc  out  OUT_CH*ACC_W  channel c's result at [c*ACC_W +: ACC_W].
REQ-018 SHALL have port overflow  out  OUT_CH  per-channel sticky saturation flag.

Function
REQ-019 SHALL implement FSM states IDLE (no beats held), ACCUM (1..NUM_BEATS-1 beats held) and DRAIN (result presented).
REQ-020 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in DRAIN; in DRAIN, in_valid and flush SHALL have no effect.
REQ-021 SHALL accept a beat on a rising edge where in_valid && in_ready.
REQ-022 SHALL, per accepted beat, for each channel c, form the sum of the sign-extended PSUM of every lane with FILTER_EN=1 and WHICH_FILTER==c; it SHALL add that sum to acc[c] at the accepting edge.
REQ-023 SHALL sum all colliding lanes that target the same channel in one beat; lanes with WHICH_FILTER >= OUT_CH SHALL be ignored.
REQ-024 SHALL count accepted beats and SHALL move to DRAIN on the edge that accepts beat NUM_BEATS; out_valid SHALL be 1 in the following cycle, so latency is 1 cycle from the last accept.
REQ-025 SHALL move to DRAIN on an edge with flush=1 in ACCUM; flush=1 in IDLE SHALL be ignored unless a beat is accepted on the same edge.
REQ-026 SHALL include a beat accepted on the same edge as flush in the result before draining.
REQ-027 SHALL hold out_valid=1 and out_acc stable in DRAIN until out_valid && out_ready; on that edge it SHALL clear acc, overflow and the beat counter and return to IDLE.
REQ-028 SHALL drive out_acc to 0 whenever out_valid=0.
REQ-029 SHALL use two's-complement arithmetic; the overflow behaviour is set by REQ-032/REQ-033.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, beat counter=0, all acc=0, out_valid=0, out_acc=0, overflow=0 and in_ready=1, independent of clk.
REQ-031 SHALL discard all partially accumulated beats on reset mid-tile or mid-DRAIN; no result SHALL be emitted for that tile.

Configuration
REQ-032 SHALL, with macro PSUM_ROUTER_SAT_EN defined, saturate each acc[c] update to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set overflow[c] on any clipped update.
REQ-033 SHALL, without PSUM_ROUTER_SAT_EN, wrap acc modulo 2^ACC_W and tie overflow to 0.

Verification
REQ-034 SHALL cover the basic tile: defaults, 4 beats, WHICH_FILTER lanes {0,1,2,3}, PSUM {1,2,3,4}, FILTER_EN=4'b1111 -> out_valid 1 cycle after the 4th accept; out_acc ch0..3 = 4,8,12,16; ch4..7 = 0.
REQ-035 SHALL cover collision and flush: 1 beat with all lanes to ch5, PSUM {10,-3,7,1}, then flush -> DRAIN; ch5=15; all other channels 0.
REQ-036 SHALL cover masking and out-of-range: OUT_CH=6, FILTER_EN=4'b0111, lane3 PSUM=100, lane2 WHICH_FILTER=7 -> lane2 and lane3 contribute nothing.
REQ-037 SHALL cover backpressure: out_ready=0 for 5 cycles in DRAIN while in_valid pulses -> out_acc stable, in_ready=0, no beat taken; after the handshake, acc=0 and in_ready=1.
REQ-038 SHALL cover saturation: ACC_W=18, 4 beats, all lanes to ch0, PSUM=32767 -> with PSUM_ROUTER_SAT_EN: ch0=131071, overflow[0]=1; without it: ch0=-16, overflow=0.
REQ-039 SHALL cover reset mid-tile: rst_n low after 2 beats -> out_valid=0, in_ready=1; the next 4-beat run with the REQ-034 data gives exactly 4,8,12,16.
